// File: rtl/rom_arb_pkg.sv
// Shared state encodings and default widths for the ROM read arbiter.
// ROM_ARB_FIXED_PRIO_EN selects fixed-priority picking instead of round-robin.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int DEF_ADDR_W  = 2;
    localparam int DEF_DATA_W  = 2;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ID_W    = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational requester picker: round-robin from ptr_i, or lowest index
// first when ROM_ARB_FIXED_PRIO_EN is defined.
module rr_pick
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = DEF_ID_W
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_oh_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    int   k;
    logic found;

`ifdef ROM_ARB_FIXED_PRIO_EN
    logic ptr_unused;
    assign ptr_unused = ^ptr_i;
`endif

    always_comb begin
        gnt_oh_o = '0;
        idx_o    = '0;
        found    = 1'b0;
        k        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
            k = i;
`else
            k = (int'(ptr_i) + i) % NUM_REQ;
`endif
            if (!found && req_i[k]) begin
                found       = 1'b1;
                gnt_oh_o[k] = 1'b1;
                idx_o       = ID_W'(k);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one combinational-read ROM among NUM_REQ requesters, one read per
// 3 cycles. ROM_ARB_FIXED_PRIO_EN switches arbitration to fixed priority.
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = DEF_ID_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ADDR_W-1:0]         rom_addr,
    output logic                      rom_read_en,
    input  logic [DATA_W-1:0]         rom_data
);

    state_e              state_q;
    logic [ID_W-1:0]     ptr_q;
    logic [ID_W-1:0]     win_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic                rsp_valid_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic                rom_read_en_q;

    logic [NUM_REQ-1:0]  pick_oh;
    logic [ID_W-1:0]     pick_idx;
    logic                pick_any;
    logic [ADDR_W-1:0]   pick_addr;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .gnt_oh_o (pick_oh),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    assign pick_addr = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            win_q         <= '0;
            gnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_data_q    <= '0;
            rom_addr_q    <= '0;
            rom_read_en_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        gnt_q         <= pick_oh;
                        rom_addr_q    <= pick_addr;
                        rom_read_en_q <= 1'b1;
                        win_q         <= pick_idx;
`ifdef ROM_ARB_FIXED_PRIO_EN
                        ptr_q         <= '0;
`else
                        ptr_q         <= (pick_idx == ID_W'(NUM_REQ-1))
                                         ? '0 : pick_idx + ID_W'(1);
`endif
                        state_q       <= ST_READ;
                    end
                end
                ST_READ: begin
                    rsp_data_q    <= rom_data;
                    rsp_id_q      <= win_q;
                    rsp_valid_q   <= 1'b1;
                    gnt_q         <= '0;
                    rom_read_en_q <= 1'b0;
                    state_q       <= ST_RESP;
                end
                ST_RESP: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign rom_addr    = rom_addr_q;
    assign rom_read_en = rom_read_en_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter; the ROM model returns ~addr.
module tb_rom_read_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [7:0] req_addr = 8'h00;
    logic [3:0] gnt;
    logic       rsp_valid;
    logic [1:0] rsp_id;
    logic [1:0] rsp_data;
    logic [1:0] rom_addr;
    logic       rom_read_en;
    logic [1:0] rom_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign rom_data = ~rom_addr;

    rom_read_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_addr    (req_addr),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rom_addr    (rom_addr),
        .rom_read_en (rom_read_en),
        .rom_data    (rom_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        req_addr = 8'b11_10_01_00;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({gnt, rsp_valid, rom_read_en} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_ctl[%0d]: got gnt=%b v=%b re=%b want 0",
                         i, gnt, rsp_valid, rom_read_en);
            end
            n_checks++;
            if ({rsp_id, rsp_data, rom_addr} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_dat[%0d]: got id=%0d d=%b a=%b want 0",
                         i, rsp_id, rsp_data, rom_addr);
            end
        end
        rst = 1'b0;
        req = 4'b0000;
        tick();
    endtask

    task automatic test_single();
        req = 4'b0100;
        req_addr = 8'b00_10_00_00;
        tick();
        n_checks++;
        if ({gnt, rom_addr, rom_read_en, rsp_valid} !== {4'b0100, 2'b10, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_gnt: got gnt=%b a=%b re=%b v=%b want 0100 10 1 0",
                     gnt, rom_addr, rom_read_en, rsp_valid);
        end
        req = 4'b0000;
        tick();
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_data, gnt, rom_read_en} !==
            {1'b1, 2'd2, 2'b01, 4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL single_rsp: got v=%b id=%0d d=%b gnt=%b re=%b want 1 2 01 0000 0",
                     rsp_valid, rsp_id, rsp_data, gnt, rom_read_en);
        end
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end: got v=%b want 0", rsp_valid);
        end
    endtask

    // Pointer sits at 3 after serving requester 2.
    task automatic test_wrap_skip();
        logic [3:0] exp_g0;
        logic [1:0] exp_a0;
        logic [1:0] exp_id0;
`ifdef ROM_ARB_FIXED_PRIO_EN
        exp_g0 = 4'b0001; exp_a0 = 2'b11; exp_id0 = 2'd0;
`else
        exp_g0 = 4'b1000; exp_a0 = 2'b00; exp_id0 = 2'd3;
`endif
        req = 4'b1001;
        req_addr = 8'b00_00_00_11;
        tick();
        n_checks++;
        if ({gnt, rom_addr} !== {exp_g0, exp_a0}) begin
            n_fail++;
            $display("FAIL wrap_gnt0: got gnt=%b a=%b want %b %b",
                     gnt, rom_addr, exp_g0, exp_a0);
        end
        tick();
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, exp_id0, ~exp_a0}) begin
            n_fail++;
            $display("FAIL wrap_rsp0: got v=%b id=%0d d=%b want 1 %0d %b",
                     rsp_valid, rsp_id, rsp_data, exp_id0, ~exp_a0);
        end
        req = 4'b1001 & ~exp_g0;
        tick();
        tick();
        n_checks++;
        if ({gnt, rom_addr} !== {~exp_g0 & 4'b1001, ~exp_a0}) begin
            n_fail++;
            $display("FAIL wrap_gnt1: got gnt=%b a=%b want %b %b",
                     gnt, rom_addr, ~exp_g0 & 4'b1001, ~exp_a0);
        end
        req = 4'b0000;
        tick();
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd3 - exp_id0, exp_a0}) begin
            n_fail++;
            $display("FAIL wrap_rsp1: got v=%b id=%0d d=%b want 1 %0d %b",
                     rsp_valid, rsp_id, rsp_data, 2'd3 - exp_id0, exp_a0);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] w;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        req_addr = 8'b11_10_01_00;
        for (int n = 0; n < 5; n++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
            w = 2'd0;
`else
            w = 2'(n % 4);
`endif
            tick();
            n_checks++;
            if ({gnt, rom_addr, rom_read_en} !== {4'b0001 << w, w, 1'b1}) begin
                n_fail++;
                $display("FAIL rr_gnt[%0d]: got gnt=%b a=%b re=%b want %b %b 1",
                         n, gnt, rom_addr, rom_read_en, 4'b0001 << w, w);
            end
            tick();
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, w, ~w}) begin
                n_fail++;
                $display("FAIL rr_rsp[%0d]: got v=%b id=%0d d=%b want 1 %0d %b",
                         n, rsp_valid, rsp_id, rsp_data, w, ~w);
            end
            if (n == 4) req = 4'b0000;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        req = 4'b0100;
        req_addr = 8'b00_10_01_00;
        tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({rsp_valid, gnt, rom_read_en, rom_addr} !== 8'b0) begin
            n_fail++;
            $display("FAIL rstmid_out: got v=%b gnt=%b re=%b a=%b want 0",
                     rsp_valid, gnt, rom_read_en, rom_addr);
        end
        rst = 1'b0;
        req = 4'b1010;
        tick();
        n_checks++;
        if ({rsp_valid, gnt, rom_addr} !== {1'b0, 4'b0010, 2'b01}) begin
            n_fail++;
            $display("FAIL rstmid_gnt: got v=%b gnt=%b a=%b want 0 0010 01",
                     rsp_valid, gnt, rom_addr);
        end
        req = 4'b0000;
        tick();
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, 2'b10}) begin
            n_fail++;
            $display("FAIL rstmid_rsp: got v=%b id=%0d d=%b want 1 1 10",
                     rsp_valid, rsp_id, rsp_data);
        end
        tick();
    endtask

    task automatic test_addr_hold();
        req = 4'b0010;
        req_addr = 8'b00_00_01_00;
        tick();
        n_checks++;
        if ({gnt, rom_addr} !== {4'b0010, 2'b01}) begin
            n_fail++;
            $display("FAIL hold_gnt: got gnt=%b a=%b want 0010 01", gnt, rom_addr);
        end
        req_addr = 8'b00_00_11_00;
        req = 4'b0000;
        tick();
        n_checks++;
        if ({rsp_valid, rsp_data, rom_addr} !== {1'b1, 2'b10, 2'b01}) begin
            n_fail++;
            $display("FAIL hold_rsp: got v=%b d=%b a=%b want 1 10 01",
                     rsp_valid, rsp_data, rom_addr);
        end
        tick();
        tick();
        n_checks++;
        if ({gnt, rsp_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL hold_idle: got gnt=%b v=%b want 0", gnt, rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap_skip();
        test_round_robin();
        test_reset_mid();
        test_addr_hold();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
